// File: rtl/seq_det_arb.sv
// Round-robin byte arbiter feeding a shared serial pattern detector, with per-channel hit counters.
// Optional macro SEQ_ARB_HOLD_EN: skip the detector flush when the same channel is granted again.
module seq_det_arb (
    input  logic        clk,
    input  logic        res,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        det_d_in,
    output logic        det_valid,
    output logic        det_res,
    input  logic        det_hit,
    output logic        done_vld,
    output logic [1:0]  done_ch,
    output logic [3:0]  done_hits,
    input  logic [1:0]  cnt_sel,
    output logic [7:0]  cnt_out,
    input  logic        cnt_clr
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        SHIFT,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  owner_q, owner_d;
    logic        owner_vld_q, owner_vld_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_q, bit_d;
    logic [3:0]  hits_q, hits_d;
    logic        done_vld_q, done_vld_d;
    logic [1:0]  done_ch_q, done_ch_d;
    logic [3:0]  done_hits_q, done_hits_d;
    logic [7:0]  cnt_q [4];
    logic [7:0]  cnt_d [4];

    logic        grant_any;
    logic [1:0]  grant_ch;
    logic [1:0]  cand;
    logic        flush_need;
    logic        hit_count;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        grant_any = 1'b0;
        grant_ch  = last_q + 2'd1;
        cand      = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_q + i[1:0];
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_ch  = cand;
            end
        end
    end

`ifdef SEQ_ARB_HOLD_EN
    assign flush_need = !(owner_vld_q && (owner_q == grant_ch));
`else
    assign flush_need = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        shreg_d     = shreg_q;
        bit_d       = bit_q;
        hits_d      = hits_q;
        done_vld_d  = 1'b0;
        done_ch_d   = done_ch_q;
        done_hits_d = done_hits_q;
        req_ready   = '0;
        det_valid   = 1'b0;
        det_d_in    = 1'b0;
        hit_count   = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req_ready   = 4'b0001 << grant_ch;
                    shreg_d     = req_data[{grant_ch, 3'b000} +: 8];
                    owner_d     = grant_ch;
                    owner_vld_d = 1'b1;
                    last_d      = grant_ch;
                    hits_d      = '0;
                    bit_d       = '0;
                    state_d     = flush_need ? FLUSH : SHIFT;
                end
            end
            FLUSH: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                det_valid = 1'b1;
                det_d_in  = shreg_q[7];
                shreg_d   = {shreg_q[6:0], 1'b0};
                bit_d     = bit_q + 3'd1;
                // The detector's registered hit lags its bit by one cycle, so SHIFT cycle 1 hits belong to the previous context.
                hit_count = det_hit && (bit_q != 3'd0);
                if (bit_q == 3'd7) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                hit_count   = det_hit;
                done_vld_d  = 1'b1;
                done_ch_d   = owner_q;
                done_hits_d = hits_q + {3'b000, det_hit};
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (hit_count) begin
            hits_d = hits_q + 4'd1;
        end

        if (res) begin
            req_ready = '0;
            det_valid = 1'b0;
            det_d_in  = 1'b0;
            hit_count = 1'b0;
        end
    end

    // Clear is applied last so it overrides a coincident increment.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (hit_count && (owner_q == i[1:0]) && (cnt_q[i] != 8'hFF)) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
            if (cnt_clr && (cnt_sel == i[1:0])) begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= IDLE;
            last_q      <= 2'd3;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            shreg_q     <= '0;
            bit_q       <= '0;
            hits_q      <= '0;
            done_vld_q  <= 1'b0;
            done_ch_q   <= '0;
            done_hits_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            shreg_q     <= shreg_d;
            bit_q       <= bit_d;
            hits_q      <= hits_d;
            done_vld_q  <= done_vld_d;
            done_ch_q   <= done_ch_d;
            done_hits_q <= done_hits_d;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign det_res   = res | (state_q == FLUSH);
    assign done_vld  = done_vld_q & ~res;
    assign done_ch   = done_vld ? done_ch_q : '0;
    assign done_hits = done_vld ? done_hits_q : '0;
    assign cnt_out   = cnt_q[cnt_sel];

endmodule

// File: tb/tb_seq_det_arb.sv
// Randomized bench for seq_det_arb against a transaction-level model of grant order, timing and hit counting.
module tb_seq_det_arb;

    logic        clk = 1'b0;
    logic        res;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        det_d_in;
    logic        det_valid;
    logic        det_res;
    logic        det_hit;
    logic        done_vld;
    logic [1:0]  done_ch;
    logic [3:0]  done_hits;
    logic [1:0]  cnt_sel;
    logic [7:0]  cnt_out;
    logic        cnt_clr;

    int vectors = 0;
    int errors  = 0;

    int m_last;
    int m_owner;
    bit m_owner_vld;
    int m_cnt [4];
    bit m_pend;
    int m_pend_ch;
    int m_pend_hits;
    bit hold_en;

    always #5 clk = ~clk;

    seq_det_arb dut (
        .clk       (clk),
        .res       (res),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .det_d_in  (det_d_in),
        .det_valid (det_valid),
        .det_res   (det_res),
        .det_hit   (det_hit),
        .done_vld  (done_vld),
        .done_ch   (done_ch),
        .done_hits (done_hits),
        .cnt_sel   (cnt_sel),
        .cnt_out   (cnt_out),
        .cnt_clr   (cnt_clr)
    );

    task automatic model_reset();
        m_last      = 3;
        m_owner     = 0;
        m_owner_vld = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_pend      = 1'b0;
    endtask

    task automatic test_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            res       = 1'b1;
            req_valid = 4'hF;
            req_data  = $urandom;
            det_hit   = 1'(i % 2);
            cnt_sel   = 2'(i % 4);
            cnt_clr   = 1'b0;
            #1;
            vectors++;
            if (req_ready !== 4'h0 || det_valid !== 1'b0 || det_d_in !== 1'b0) begin
                errors++;
                $display("FAIL reset_outs: ready=%h valid=%b din=%b want 0/0/0", req_ready, det_valid, det_d_in);
            end
            vectors++;
            if (det_res !== 1'b1) begin
                errors++;
                $display("FAIL reset_det_res: got %b want 1", det_res);
            end
            vectors++;
            if (done_vld !== 1'b0 || done_ch !== 2'd0 || done_hits !== 4'd0) begin
                errors++;
                $display("FAIL reset_done: vld=%b ch=%0d hits=%0d want 0/0/0", done_vld, done_ch, done_hits);
            end
            if (i > 0) begin
                vectors++;
                if (cnt_out !== 8'd0) begin
                    errors++;
                    $display("FAIL reset_cnt: sel=%0d got %0d want 0", cnt_sel, cnt_out);
                end
            end
        end
        model_reset();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            res       = 1'b0;
            req_valid = 4'h0;
            req_data  = $urandom;
            det_hit   = 1'($urandom_range(0, 1));
            cnt_sel   = 2'(i % 4);
            cnt_clr   = 1'b0;
            #1;
            vectors++;
            if (req_ready !== 4'h0 || det_valid !== 1'b0 || det_d_in !== 1'b0 || det_res !== 1'b0) begin
                errors++;
                $display("FAIL idle_outs: ready=%h valid=%b din=%b dres=%b want 0", req_ready, det_valid, det_d_in, det_res);
            end
            vectors++;
            if (done_vld !== m_pend) begin
                errors++;
                $display("FAIL idle_done_vld: got %b want %b", done_vld, m_pend);
            end
            if (m_pend) begin
                vectors++;
                if (done_ch !== 2'(m_pend_ch) || done_hits !== 4'(m_pend_hits)) begin
                    errors++;
                    $display("FAIL idle_done_data: ch=%0d hits=%0d want ch=%0d hits=%0d", done_ch, done_hits, m_pend_ch, m_pend_hits);
                end
            end
            vectors++;
            if (cnt_out !== 8'(m_cnt[cnt_sel])) begin
                errors++;
                $display("FAIL idle_cnt: sel=%0d got %0d want %0d", cnt_sel, cnt_out, m_cnt[cnt_sel]);
            end
            m_pend = 1'b0;
        end
    endtask

    // One byte transaction from its grant cycle through DRAIN; the done pulse is checked by whatever runs next.
    task automatic run_txn(input logic [3:0] vmask, input logic [31:0] data, input logic [10:0] hitmask,
                           input int clr_t, input int abort_t, input string tag);
        int ch, s0, len, hits, sel;
        bit flush, exp_valid, exp_bit, exp_dres, exp_done;
        logic [3:0] exp_ready;
        logic [7:0] b;
        ch = -1;
        for (int k = 1; k <= 4; k++) begin
            if (ch < 0 && vmask[(m_last + k) % 4]) ch = (m_last + k) % 4;
        end
        flush = !(hold_en && m_owner_vld && m_owner == ch);
        s0    = flush ? 2 : 1;
        len   = s0 + 9;
        hits  = 0;
        b     = data[8*ch +: 8];
        for (int t = 0; t < len; t++) begin
            @(posedge clk); #1;
            res       = (t == abort_t);
            req_valid = vmask;
            req_data  = data;
            det_hit   = hitmask[t];
            sel       = $urandom_range(0, 3);
            cnt_clr   = 1'b0;
            if (t == clr_t) begin
                sel     = ch;
                cnt_clr = 1'b1;
            end
            cnt_sel = 2'(sel);
            #1;
            if (t == abort_t) begin
                vectors++;
                if (req_ready !== 4'h0 || det_valid !== 1'b0 || det_d_in !== 1'b0 || det_res !== 1'b1 || done_vld !== 1'b0) begin
                    errors++;
                    $display("FAIL %s abort_outs: ready=%h valid=%b din=%b dres=%b done=%b want 0/0/0/1/0",
                             tag, req_ready, det_valid, det_d_in, det_res, done_vld);
                end
                model_reset();
                return;
            end
            exp_ready = (t == 0) ? (4'b0001 << ch) : 4'b0000;
            exp_valid = (t >= s0) && (t < s0 + 8);
            exp_bit   = exp_valid ? b[7 - (t - s0)] : 1'b0;
            exp_dres  = flush && (t == 1);
            exp_done  = (t == 0) && m_pend;
            vectors++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL %s ready t=%0d: got %h want %h", tag, t, req_ready, exp_ready);
            end
            vectors++;
            if (det_valid !== exp_valid || det_d_in !== exp_bit) begin
                errors++;
                $display("FAIL %s serial t=%0d: valid=%b din=%b want valid=%b din=%b", tag, t, det_valid, det_d_in, exp_valid, exp_bit);
            end
            vectors++;
            if (det_res !== exp_dres) begin
                errors++;
                $display("FAIL %s det_res t=%0d: got %b want %b", tag, t, det_res, exp_dres);
            end
            vectors++;
            if (done_vld !== exp_done) begin
                errors++;
                $display("FAIL %s done_vld t=%0d: got %b want %b", tag, t, done_vld, exp_done);
            end
            if (exp_done) begin
                vectors++;
                if (done_ch !== 2'(m_pend_ch) || done_hits !== 4'(m_pend_hits)) begin
                    errors++;
                    $display("FAIL %s done_data: ch=%0d hits=%0d want ch=%0d hits=%0d", tag, done_ch, done_hits, m_pend_ch, m_pend_hits);
                end
            end
            vectors++;
            if (cnt_out !== 8'(m_cnt[sel])) begin
                errors++;
                $display("FAIL %s cnt t=%0d sel=%0d: got %0d want %0d", tag, t, sel, cnt_out, m_cnt[sel]);
            end
            if (t == 0) m_pend = 1'b0;
            // Hits count from SHIFT cycle 2 through DRAIN inclusive.
            if (hitmask[t] && t > s0 && t <= s0 + 8) begin
                hits++;
                if (m_cnt[ch] < 255) m_cnt[ch]++;
            end
            if (cnt_clr) m_cnt[sel] = 0;
        end
        m_last      = ch;
        m_owner     = ch;
        m_owner_vld = 1'b1;
        m_pend      = 1'b1;
        m_pend_ch   = ch;
        m_pend_hits = hits;
    endtask

    task automatic test_single();
        test_reset(2);
        run_txn(4'h1, 32'h0000_00D0, 11'h000, -1, -1, "single");
        idle_cycles(2);
    endtask

    task automatic test_round_robin();
        test_reset(2);
        for (int i = 0; i < 5; i++) run_txn(4'hF, $urandom, 11'h000, -1, -1, "rr");
        idle_cycles(1);
    endtask

    task automatic test_hits();
        // Previous owner is 0, so a flush precedes this byte: FLUSH t=1, SHIFT 4 t=5, DRAIN t=10.
        run_txn(4'h4, $urandom, 11'b100_0010_0010, -1, -1, "hits");
        idle_cycles(4);
    endtask

    task automatic test_saturate();
        test_reset(1);
        for (int i = 0; i < 32; i++) run_txn(4'h2, $urandom, 11'h7FF, -1, -1, "sat");
        idle_cycles(4);
        run_txn(4'h2, $urandom, 11'h7FF, (hold_en ? 9 : 10), -1, "clr");
        idle_cycles(4);
    endtask

    task automatic test_reset_mid();
        test_reset(1);
        run_txn(4'h1, $urandom, 11'($urandom), -1, 6, "abort");
        run_txn(4'hF, $urandom, 11'h000, -1, -1, "after_abort");
        idle_cycles(4);
    endtask

    task automatic test_back_to_back();
        run_txn(4'h8, $urandom, 11'($urandom), -1, -1, "b2b_a");
        run_txn(4'h8, $urandom, 11'($urandom), -1, -1, "b2b_b");
        run_txn(4'h8, $urandom, 11'($urandom), -1, -1, "b2b_c");
        idle_cycles(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn(4'($urandom_range(1, 15)), $urandom, 11'($urandom),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1, -1, "rand");
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
        end
        idle_cycles(4);
    endtask

    initial begin
`ifdef SEQ_ARB_HOLD_EN
        hold_en = 1'b1;
`else
        hold_en = 1'b0;
`endif
        res       = 1'b1;
        req_valid = 4'h0;
        req_data  = '0;
        det_hit   = 1'b0;
        cnt_sel   = 2'd0;
        cnt_clr   = 1'b0;
        model_reset();

        test_reset(3);
        test_single();
        test_round_robin();
        test_hits();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
